// File: rtl/alu_result_disp.sv
// alu_result_disp: captures ALU sum/cout/overflow on en; drives 4-digit muxed active-low 7-seg (seg {dp,g..a}, an one-hot low) with overflow blink, plus led=cout and ovf_led=overflow
module alu_result_disp #(
  parameter int SCAN_DIV  = 1000,
  parameter int BLINK_DIV = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] sum,
  input  logic [3:0] cout,
  input  logic       overflow,
  input  logic       signed_mode,
  output logic [7:0] seg,
  output logic [3:0] an,
  output logic [3:0] led,
  output logic       ovf_led
);
  localparam int SW = $clog2(SCAN_DIV + 1);
  localparam int BW = $clog2(BLINK_DIV + 1);
  localparam logic [127:0] HEX = {8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
                                  8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0};
  typedef enum logic [1:0] {D0, D1, D2, D3} state_t;
  state_t state, state_n;
  logic [SW-1:0] scan_cnt, scan_cnt_n;
  logic [BW-1:0] blink_cnt;
  logic phase, scan_wrap, neg, ovf_q, sm_q;
  logic [3:0] sum_q, cout_q, mag;
  logic [7:0] glyph;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state    <= D0;
      scan_cnt <= '0;
    end else begin
      state    <= state_n;
      scan_cnt <= scan_cnt_n;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sum_q     <= '0;
      cout_q    <= '0;
      ovf_q     <= 1'b0;
      sm_q      <= 1'b0;
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (en) begin
      sum_q     <= sum;
      cout_q    <= cout;
      ovf_q     <= overflow;
      sm_q      <= signed_mode;
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
      blink_cnt <= '0;
      phase     <= ~phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  always_comb begin
    scan_wrap  = scan_cnt == SW'(SCAN_DIV - 1);
    scan_cnt_n = scan_wrap ? '0 : scan_cnt + 1'b1;
    state_n    = scan_wrap ? state_t'(state + 2'd1) : state;
    neg        = sm_q & sum_q[3];
    mag        = neg ? -sum_q : sum_q;
    glyph      = state == D0 ? HEX[{mag, 3'b000} +: 8] :
                 state == D1 ? (neg ? 8'hBF : 8'hFF) :
                 state == D2 ? (cout_q[3] ? 8'hC6 : 8'hFF) :
                               (ovf_q ? 8'hA3 : 8'hFF);
    seg        = (ovf_q & phase) ? 8'hFF : glyph;
    an         = ~(4'b0001 << state);
    led        = cout_q;
    ovf_led    = ovf_q;
  end
endmodule

// File: tb/tb_alu_result_disp.sv
// tb_alu_result_disp: table-driven scoreboard bench for alu_result_disp
module tb_alu_result_disp;
  logic clk = 0, rst = 1, en = 0, overflow = 0, signed_mode = 0;
  logic [3:0] sum = 0, cout = 0, an, led;
  logic [7:0] seg;
  logic ovf_led;
  int checks = 0, errors = 0;

  alu_result_disp #(.SCAN_DIV(2), .BLINK_DIV(4)) dut (
    .clk(clk), .rst(rst), .en(en), .sum(sum), .cout(cout), .overflow(overflow),
    .signed_mode(signed_mode), .seg(seg), .an(an), .led(led), .ovf_led(ovf_led));

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] sum, cout;
    logic ovf, sm;
    logic [3:0][7:0] d;
  } vec_t;

  vec_t vecs[8];
  vec_t sb[$];
  vec_t cur;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int an_idx(input logic [3:0] a);
    case (a)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic capture(input vec_t v);
    @(negedge clk);
    sum = v.sum; cout = v.cout; overflow = v.ovf; signed_mode = v.sm; en = 1;
    sb.push_back(v);
    tick();
    en = 0;
  endtask

  task automatic check_disp(input string name, input vec_t v, input int k);
    int i;
    i = an_idx(an);
    chk({name, "_an"}, {7'd0, i >= 0}, 8'd1);
    if (i >= 0)
      chk({name, "_seg"}, seg, (v.ovf && ((k / 4) % 2 == 1)) ? 8'hFF : v.d[i]);
    chk({name, "_led"}, {4'd0, led}, {4'd0, v.cout});
    chk({name, "_ovf"}, {7'd0, ovf_led}, {7'd0, v.ovf});
  endtask

  initial begin
    vecs[0] = '{4'hB, 4'b0011, 0, 0, {8'hFF, 8'hFF, 8'hFF, 8'h83}};
    vecs[1] = '{4'b1011, 4'b1111, 0, 1, {8'hFF, 8'hC6, 8'hBF, 8'h92}};
    vecs[2] = '{4'b1000, 4'b0000, 0, 1, {8'hFF, 8'hFF, 8'hBF, 8'h80}};
    vecs[3] = '{4'b0111, 4'b1000, 1, 1, {8'hA3, 8'hC6, 8'hFF, 8'hF8}};
    vecs[4] = '{4'hF, 4'b0000, 0, 0, {8'hFF, 8'hFF, 8'hFF, 8'h8E}};
    vecs[5] = '{4'hF, 4'b0111, 1, 1, {8'hA3, 8'hFF, 8'hBF, 8'hF9}};
    vecs[6] = '{4'h0, 4'b0000, 0, 1, {8'hFF, 8'hFF, 8'hFF, 8'hC0}};
    vecs[7] = '{4'hA, 4'b1010, 0, 0, {8'hFF, 8'hC6, 8'hFF, 8'h88}};

    #1;
    chk("rst_an", {4'd0, an}, 8'h0E);
    chk("rst_seg", seg, 8'hC0);
    chk("rst_led", {4'd0, led}, 8'h00);
    chk("rst_ovf", {7'd0, ovf_led}, 8'h00);
    repeat (2) @(negedge clk);
    rst = 0;

    foreach (vecs[n]) begin
      capture(vecs[n]);
      cur = sb.pop_front();
      for (int k = 0; k < 16; k++) begin
        check_disp($sformatf("vec%0d_k%0d", n, k), cur, k);
        tick();
      end
    end

    // overflow captured, then recapture while blanked
    capture(vecs[3]);
    cur = sb.pop_front();
    repeat (5) tick();
    chk("blank_seg", seg, 8'hFF);
    chk("blank_ovf", {7'd0, ovf_led}, 8'h01);
    capture(vecs[5]);
    cur = sb.pop_front();
    check_disp("recap", cur, 0);

    // hold with en low
    capture(vecs[1]);
    cur = sb.pop_front();
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      sum = 4'($urandom); cout = 4'($urandom); overflow = 1'($urandom); signed_mode = 1'($urandom);
      tick();
      check_disp("hold", cur, 0);
    end

    // reset mid-scan at D2 with overflow captured
    capture(vecs[3]);
    cur = sb.pop_front();
    begin
      int t = 0;
      while (an != 4'b1011 && t < 16) begin tick(); t++; end
      chk("rst_wait_d2", {7'd0, an == 4'b1011}, 8'd1);
    end
    @(negedge clk);
    #2 rst = 1;
    #1;
    chk("mrst_an", {4'd0, an}, 8'h0E);
    chk("mrst_seg", seg, 8'hC0);
    chk("mrst_led", {4'd0, led}, 8'h00);
    chk("mrst_ovf", {7'd0, ovf_led}, 8'h00);
    @(negedge clk);
    rst = 0;
    tick();
    chk("rel_an1", {4'd0, an}, 8'h0E);
    tick();
    chk("rel_an2", {4'd0, an}, 8'h0D);
    chk("rel_seg2", seg, 8'hFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
